// File: rtl/rca_stream_accumulator.sv
// ---------------------------------------------------------------------------
// rca_stream_accumulator
//
// Purpose:
//   Sequential front/back end for an external combinational ripple-carry
//   adder. Operands arrive on a valid/ready stream. Each operand is added to
//   a running N-bit accumulator by the external adder. A sticky overflow flag
//   and a saturating operand count are kept with the sum. When the operand
//   marked last has been added, the group total is held on a valid/ready
//   output until it is taken.
//
// Ports:
//   clk        in   1      single clock, rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand valid
//   in_ready   out  1      operand can be accepted this cycle
//   in_data    in   N      unsigned operand
//   in_last    in   1      operand closes the current group
//   add_a      out  N      adder num1: accumulator
//   add_b      out  N      adder num2: registered operand
//   add_sum    in   N+1    adder result, bit N = carry-out
//   out_valid  out  1      group total available
//   out_ready  in   1      consumer takes the total
//   out_sum    out  N      group sum modulo 2^N
//   out_ovf    out  1      some addition in the group carried out
//   out_count  out  CNT_W  operands in the group, saturating
// ---------------------------------------------------------------------------
module rca_stream_accumulator #(
    parameter int N     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic [N-1:0]     add_a,
    output logic [N-1:0]     add_b,
    input  logic [N:0]       add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        ST_ACCEPT,
        ST_ADD,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [N-1:0]     acc;
    logic [N-1:0]     op_reg;
    logic             last_reg;
    logic             ovf;
    logic [CNT_W-1:0] count;

    // Next-state decode.
    always_comb begin
        // NOTE: default first so every path assigns state_next; no latch.
        state_next = state;
        case (state)
            ST_ACCEPT: if (in_valid) state_next = ST_ADD;
            ST_ADD:    state_next = last_reg ? ST_DONE : ST_ACCEPT;
            ST_DONE:   if (out_ready) state_next = ST_ACCEPT;
            default:   state_next = ST_ACCEPT;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) begin
            state    <= ST_ACCEPT;
            acc      <= '0;
            op_reg   <= '0;
            last_reg <= 1'b0;
            ovf      <= 1'b0;
            count    <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_ACCEPT: begin
                    if (in_valid) begin
                        op_reg   <= in_data;
                        last_reg <= in_last;
                    end
                end
                ST_ADD: begin
                    // The adder has settled on acc + op_reg during this cycle.
                    acc <= add_sum[N-1:0];
                    ovf <= ovf | add_sum[N];
                    if (count != '1) count <= count + CNT_W'(1);
                end
                ST_DONE: begin
                    if (out_ready) begin
                        acc   <= '0;
                        ovf   <= 1'b0;
                        count <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode from state and registers only; nothing flows from in_* to out_*.
    assign in_ready  = (state == ST_ACCEPT);
    assign out_valid = (state == ST_DONE);
    assign add_a     = acc;
    assign add_b     = op_reg;
    assign out_sum   = acc;
    assign out_ovf   = ovf;
    assign out_count = count;

endmodule

// File: tb/tb_rca_stream_accumulator.sv
// ---------------------------------------------------------------------------
// tb_rca_stream_accumulator
//
// Purpose:
//   Self-checking bench for rca_stream_accumulator. Two instances share all
//   stimulus: one with CNT_W=8 and one with CNT_W=2, so that count
//   saturation is exercised alongside the normal function. Each instance has
//   its own behavioural adder. The expected totals come from a group model
//   that keeps the plain integer sum and operand count of the open group.
// ---------------------------------------------------------------------------
module tb_rca_stream_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_ready;

    logic       in_ready_w, out_valid_w, out_ovf_w;
    logic [7:0] add_a_w, add_b_w, out_sum_w, out_count_w;
    logic [8:0] add_sum_w;

    logic       in_ready_s, out_valid_s, out_ovf_s;
    logic [7:0] add_a_s, add_b_s, out_sum_s;
    logic [1:0] out_count_s;
    logic [8:0] add_sum_s;

    int checks = 0;
    int errors = 0;

    // Group model: plain integer total and operand count of the open group.
    int grp_sum = 0;
    int grp_n   = 0;

    always #5 clk = ~clk;

    // External adders.
    assign add_sum_w = {1'b0, add_a_w} + {1'b0, add_b_w};
    assign add_sum_s = {1'b0, add_a_s} + {1'b0, add_b_s};

    rca_stream_accumulator #(.N(8), .CNT_W(8)) dut_w (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data), .in_last(in_last),
        .add_a(add_a_w), .add_b(add_b_w), .add_sum(add_sum_w),
        .out_valid(out_valid_w), .out_ready(out_ready),
        .out_sum(out_sum_w), .out_ovf(out_ovf_w), .out_count(out_count_w)
    );

    rca_stream_accumulator #(.N(8), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data), .in_last(in_last),
        .add_a(add_a_s), .add_b(add_b_s), .add_sum(add_sum_s),
        .out_valid(out_valid_s), .out_ready(out_ready),
        .out_sum(out_sum_s), .out_ovf(out_ovf_s), .out_count(out_count_s)
    );

    // Hand one operand over; starts and ends at a falling edge.
    task automatic send(input logic [7:0] d, input logic l);
        int         waited;
        logic [7:0] exp_a;
        waited = 0;
        while (!(in_ready_w && in_ready_s) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if ({in_ready_w, in_ready_s} !== 2'b11) begin
            errors++;
            $display("FAIL send_wait: in_ready w/s=%b%b, required 11", in_ready_w, in_ready_s);
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
        exp_a    = grp_sum[7:0];
        checks++;
        if ({add_a_w, add_b_w, add_a_s, add_b_s, in_ready_w, in_ready_s, out_valid_w, out_valid_s}
            !== {exp_a, d, exp_a, d, 4'b0000}) begin
            errors++;
            $display("FAIL add_operands: a w/s=%h/%h b w/s=%h/%h rdy=%b%b vld=%b%b, required a=%h b=%h rdy=00 vld=00",
                     add_a_w, add_a_s, add_b_w, add_b_s, in_ready_w, in_ready_s,
                     out_valid_w, out_valid_s, exp_a, d);
        end
        grp_sum += int'(d);
        grp_n++;
    endtask

    // Wait for the total, hold it for hold cycles, then take it.
    task automatic receive(input int hold);
        int         waited;
        logic [7:0] es;
        logic       eo;
        logic [7:0] ecw;
        logic [1:0] ecs;
        waited = 0;
        while (!out_valid_w && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (out_valid_w !== 1'b1) begin
            errors++;
            $display("FAIL recv_wait: out_valid=%b, required 1", out_valid_w);
            return;
        end
        es  = grp_sum[7:0];
        eo  = (grp_sum > 255);
        ecw = (grp_n > 255) ? 8'd255 : grp_n[7:0];
        ecs = (grp_n > 3) ? 2'd3 : grp_n[1:0];
        for (int c = 0; c <= hold; c++) begin
            checks++;
            if ({out_sum_w, out_ovf_w, out_count_w, out_sum_s, out_ovf_s, out_count_s,
                 out_valid_w, out_valid_s, in_ready_w, in_ready_s}
                !== {es, eo, ecw, es, eo, ecs, 4'b1100}) begin
                errors++;
                $display("FAIL total[%0d]: sum=%h/%h ovf=%b/%b cnt=%0d/%0d vld=%b%b rdy=%b%b, required sum=%h ovf=%b cnt=%0d/%0d vld=11 rdy=00",
                         c, out_sum_w, out_sum_s, out_ovf_w, out_ovf_s, out_count_w, out_count_s,
                         out_valid_w, out_valid_s, in_ready_w, in_ready_s, es, eo, ecw, ecs);
            end
            if (c < hold) begin
                // Junk on the input side must be ignored while the total waits.
                in_valid = 1'b1;
                in_data  = 8'($urandom);
                in_last  = 1'($urandom);
                @(posedge clk);
                @(negedge clk);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        grp_sum   = 0;
        grp_n     = 0;
        checks++;
        if ({out_valid_w, out_valid_s, in_ready_w, in_ready_s, add_a_w, add_a_s, out_count_w, out_count_s, out_ovf_w}
            !== {4'b0011, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0}) begin
            errors++;
            $display("FAIL cleared: vld=%b%b rdy=%b%b acc=%h/%h cnt=%0d/%0d ovf=%b, required vld=00 rdy=11 acc=00 cnt=0 ovf=0",
                     out_valid_w, out_valid_s, in_ready_w, in_ready_s, add_a_w, add_a_s,
                     out_count_w, out_count_s, out_ovf_w);
        end
    endtask

    task automatic check_reset_state(input string name);
        checks++;
        if ({out_valid_w, out_valid_s, in_ready_w, in_ready_s, add_a_w, add_b_w, add_a_s, add_b_s,
             out_ovf_w, out_ovf_s, out_count_w, out_count_s}
            !== {4'b0011, 32'h0, 2'b00, 8'h00, 2'b00}) begin
            errors++;
            $display("FAIL %s: vld=%b%b rdy=%b%b a=%h/%h b=%h/%h ovf=%b%b cnt=%0d/%0d, required vld=00 rdy=11 all else 0",
                     name, out_valid_w, out_valid_s, in_ready_w, in_ready_s, add_a_w, add_a_s,
                     add_b_w, add_b_s, out_ovf_w, out_ovf_s, out_count_w, out_count_s);
        end
        grp_sum = 0;
        grp_n   = 0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        in_last   = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b0;
        check_reset_state("reset");
    endtask

    task automatic test_single();
        send(8'hFF, 1'b1);
        @(negedge clk);
        checks++;
        if ({out_valid_w, out_valid_s} !== 2'b11) begin
            errors++;
            $display("FAIL single_latency: out_valid=%b%b, required 11", out_valid_w, out_valid_s);
        end
        receive(0);
    endtask

    task automatic test_groups();
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b1);
        receive(0);
        send(8'h0F, 1'b0);
        send(8'hF0, 1'b1);
        receive(0);
        // Carry on an inner addition only: the flag must stay sticky.
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h01, 1'b1);
        receive(0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] ops [3];
        logic       exp_rdy [6];
        logic       rdy;
        int         idx;
        ops = '{8'h37, 8'h43, 8'h03};
        exp_rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        idx = 0;
        in_valid = 1'b1;
        in_data  = ops[0];
        in_last  = 1'b0;
        for (int c = 0; c < 6; c++) begin
            rdy = in_ready_w;
            checks++;
            if ({in_ready_w, in_ready_s} !== {2{exp_rdy[c]}}) begin
                errors++;
                $display("FAIL b2b_ready[%0d]: in_ready=%b%b, required %b", c, in_ready_w, in_ready_s, exp_rdy[c]);
            end
            if (rdy && idx < 3) begin
                in_data = ops[idx];
                in_last = (idx == 2);
            end
            @(posedge clk);
            @(negedge clk);
            if (rdy && idx < 3) begin
                grp_sum += int'(ops[idx]);
                grp_n++;
                idx++;
            end
        end
        in_valid = 1'b0;
        receive(0);
    endtask

    task automatic test_backpressure();
        send(8'h63, 1'b0);
        send(8'h82, 1'b1);
        receive(5);
    endtask

    task automatic test_reset_mid();
        send(8'h80, 1'b0);
        send(8'h80, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset_in_add");
        send(8'h01, 1'b1);
        receive(0);
        // Reset while a total is waiting discards it.
        send(8'h55, 1'b0);
        send(8'hC0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset_in_done");
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 5; i++) send(8'h01, i == 4);
        receive(0);
    endtask

    task automatic test_random();
        int len;
        for (int g = 0; g < 25; g++) begin
            len = $urandom_range(1, 8);
            for (int i = 0; i < len; i++) begin
                send(($urandom_range(0, 1) == 1) ? 8'($urandom_range(192, 255)) : 8'($urandom),
                     i == len - 1);
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
            receive($urandom_range(0, 3));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_groups();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
